// File: rtl/aes_mode_stream_if.sv
// Plaintext-in / ciphertext-out stream bundle for aes_mode_stream.
// The mode controller connects to the slave modport; the fabric connects to the master modport.
interface aes_mode_stream_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aes_mode_stream.sv
// Streaming ECB / CBC-encrypt / CTR mode controller wrapped around one external
// AES-128 core. One block is in flight at a time. Results are queued in a small
// output FIFO, and that FIFO applies backpressure to the input stream.
module aes_mode_stream #(
  parameter int CTR_WIDTH = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [1:0]       cfg_mode,
  input  logic [127:0]     cfg_key,
  input  logic [127:0]     cfg_iv,
  output logic             cfg_err,
  aes_mode_stream_if.slave strm,
  output logic             core_valid,
  output logic [127:0]     core_key,
  output logic [127:0]     core_txt,
  input  logic [127:0]     core_cypher,
  input  logic             core_done,
  output logic             busy
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(OUT_DEPTH);

  localparam logic [1:0] M_ECB = 2'b00;
  localparam logic [1:0] M_CBC = 2'b01;
  localparam logic [1:0] M_CTR = 2'b10;
  localparam logic [1:0] M_BAD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state;
  logic [1:0]    mode;
  logic [127:0]  iv;
  logic [127:0]  chain;
  logic [127:0]  ctr;
  logic [127:0]  saved_data;
  logic          saved_last;

  logic [127:0]  fifo_data [OUT_DEPTH];
  logic          fifo_last [OUT_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          accept;
  logic          push;
  logic          pop;
  logic [127:0]  result;

  // Only the low CTR_WIDTH bits of the counter block count. The upper bits stay fixed (nonce part).
  function automatic logic [127:0] ctr_next(input logic [127:0] c);
    logic [127:0] r;
    r = c;
    r[CTR_WIDTH-1:0] = c[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
    return r;
  endfunction

  // Block handed to the core for the current mode.
  function automatic logic [127:0] issue_block(input logic [1:0]   m,
                                               input logic [127:0] d,
                                               input logic [127:0] ch,
                                               input logic [127:0] c);
    logic [127:0] b;
    case (m)
      M_CBC:   b = d ^ ch;
      M_CTR:   b = c;
      default: b = d;
    endcase
    return b;
  endfunction

  // in_ready uses the FIFO count before any pop in this cycle, so a push never lands on a full FIFO.
  assign strm.in_ready  = (state == S_IDLE) && (count < FULL) && !cfg_load;
  assign accept         = strm.in_valid && strm.in_ready;
  assign push           = (state == S_WAIT) && core_done;
  assign pop            = strm.out_valid && strm.out_ready;
  assign strm.out_valid = (count != '0);
  assign strm.out_data  = fifo_data[rd_ptr];
  assign strm.out_last  = fifo_last[rd_ptr];
  assign busy           = (state != S_IDLE) || (count != '0);
  assign result         = (mode == M_CTR) ? (core_cypher ^ saved_data) : core_cypher;

  // Mode FSM: configuration, core issue/wait, and chaining-state updates.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mode       <= M_ECB;
      core_key   <= '0;
      iv         <= '0;
      chain      <= '0;
      ctr        <= '0;
      saved_data <= '0;
      saved_last <= 1'b0;
      core_txt   <= '0;
      core_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      core_valid <= 1'b0;
      cfg_err    <= 1'b0;
      if (cfg_load) begin
        if ((state != S_IDLE) || (cfg_mode == M_BAD)) begin
          cfg_err <= 1'b1;
        end else begin
          mode     <= cfg_mode;
          core_key <= cfg_key;
          iv       <= cfg_iv;
          chain    <= cfg_iv;
          ctr      <= cfg_iv;
        end
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            saved_data <= strm.in_data;
            saved_last <= strm.in_last;
            core_txt   <= issue_block(mode, strm.in_data, chain, ctr);
            core_valid <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            if (saved_last) begin
              chain <= iv;
              ctr   <= iv;
            end else if (mode == M_CBC) begin
              chain <= core_cypher;
            end else if (mode == M_CTR) begin
              ctr <= ctr_next(ctr);
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO: push on core completion, pop on the out handshake. Both may happen in one cycle.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= result;
        fifo_last[wr_ptr] <= saved_last;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end
endmodule

// File: doc/aes_mode_stream.md
# aes_mode_stream

Streaming block-cipher mode controller for the AES-128 datapath. It accepts 128-bit plaintext beats on a ready/valid stream and drives one external AES-128 encryption core through a Valid/Done handshake. It applies ECB, CBC-encrypt or CTR chaining and buffers results in an output FIFO with backpressure. It sits between the system stream fabric and the AES-128 core, and adds multi-block messages, chaining state and flow control.

## Interface
- CTR_WIDTH, 32: number of low-order counter-block bits that increment in CTR mode (1..128).
- OUT_DEPTH, 4: output FIFO entries; power of two, at least 2.

Ports:
- CLK  in  1  clock, rising edge.
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**.
- cfg_load  in  1  one-cycle configuration strobe.
- cfg_mode  in  2  mode select: 00 ECB, 01 CBC, 10 CTR, 11 illegal.
- cfg_key  in  128  cipher key.
- cfg_iv  in  128  CBC IV or CTR initial counter block.
- cfg_err  out  1  one-cycle pulse when a cfg_load is rejected.
- in_valid / in_ready  in / out  1  plaintext handshake.
- in_data  in  128  plaintext beat.
- in_last  in  1  marks the final beat of a message.
- out_valid / out_ready  out / in  1  result handshake.
- out_data  out  128  ciphertext beat.
- out_last  out  1  in_last carried through with its beat.
- core_valid  out  1  one-cycle start pulse to the core.
- core_key  out  128  registered key, held stable.
- core_txt  out  128  core input block, held from the start pulse until done.
- core_cypher  in  128  core result.
- core_done  in  1  one-cycle pulse; core_cypher is valid in that cycle.
- busy  out  1  high when state is not IDLE or the FIFO is non-empty.

## Operation
- Registers: mode, key, iv, chain (128), ctr (128), saved data, saved last.
- FSM states:
  - IDLE: waits for a cfg_load or an input beat.
  - ISSUE: one cycle; core_valid=1.
  - WAIT: waits for core_done.
- IDLE, cfg_load=1:
  - Legal mode: mode, key and iv are written, and chain=ctr=cfg_iv.
  - Mode 11: cfg_err pulses and the configuration is unchanged.
- cfg_load has priority over in_valid in the same cycle. in_ready=0 in any cycle where cfg_load=1.
- cfg_load outside IDLE is ignored, and cfg_err pulses.
- in_ready = (state==IDLE) and (fifo_count < OUT_DEPTH) and not cfg_load. The count is sampled before any same-cycle pop.
- Input accept (in_valid and in_ready):
  - Latch data and last; go to ISSUE.
  - core_txt = data (ECB), data^chain (CBC), or ctr (CTR).
- WAIT with core_done=1: write the result to the FIFO and go to IDLE.
  - ECB: result = core_cypher.
  - CBC: result = core_cypher, and chain = core_cypher.
  - CTR: result = core_cypher^saved data. ctr low CTR_WIDTH bits increment modulo 2^CTR_WIDTH; upper bits are unchanged.
- After a beat with last=1 completes: chain=iv and ctr=iv, so the next message restarts from the IV.
- core_done is ignored in IDLE and ISSUE.
- FIFO:
  - Entries are {data, last}; out_data and out_last come from the head.
  - A pop occurs on out_valid and out_ready.
  - A push and a pop in the same cycle are both performed.
  - A push never targets a full FIFO, guaranteed by the in_ready rule.
  - Read and write pointers wrap modulo OUT_DEPTH.

## Timing
- Reset values:
  - Outputs: in_ready=1 once rst_n is high; every other output is 0, including out_data and core_txt.
  - Registers: all 0, mode=ECB, FIFO empty, state IDLE.
- Reset asserted mid-operation: the FSM goes to IDLE immediately and the FIFO is flushed. A core_done that arrives after reset is ignored.
- Beat accepted at edge t:
  - core_valid and core_txt are valid in cycle t+1.
  - If core_done arrives in cycle d (d ≥ t+2), the result is pushed at the end of d, and out_valid=1 from cycle d+1.
  - in_ready can be high again in cycle d+1.
- Throughput is one block per core latency + 2 cycles.
- out_valid stays high, and out_data stays stable, until a pop occurs.

## Test plan
- **ECB:** key 000102…0f, plaintext 00112233445566778899aabbccddeeff → out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
- **CBC:** key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102…0f.
  - Beat 6bc1bee22e409f96e93d7e117393172a → 7649abac8119b246cee98e9b12e9197d.
  - Beat ae2d8a571e03ac9c9eb76fac45af8e51 with last=1 → 5086cb9b507219ee95db113a917678b2.
  - Resend the first beat → 7649abac… again.
- **CTR:** same key, IV f0f1…feff, beat 6bc1bee2… → 874d6191b620e3261bef6864990db6ce. core_txt for the second beat = f0f1…fe00 with CTR_WIDTH=8, and f0f1…fdff00 with CTR_WIDTH=32.
- **Backpressure:** OUT_DEPTH=4, out_ready=0, five beats offered.
  - in_ready drops after 4 results are buffered.
  - Raising out_ready drains results in order, with out_last correct, and the fifth beat then completes.
- **Config and reset:**
  - cfg_load with mode 11 → cfg_err pulse and mode unchanged.
  - cfg_load during WAIT → cfg_err pulse.
  - rst_n low during WAIT, then a late core_done → no FIFO push, and out_valid stays 0.
